// File: rtl/tok_pkg.sv
// Shared definitions for the identifier token collector: delimiter set,
// character-class helpers, FSM states and the default output record layout.
package tok_pkg;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_NEWLINE = 8'h0A;
  localparam logic [7:0] CH_COMMA   = 8'h2C;
  localparam logic [7:0] CH_SEMI    = 8'h3B;

  localparam int unsigned REC_POS_W = 16;
  localparam int unsigned REC_LEN_W = 8;

  typedef enum logic {GAP, TOKEN} tok_state_e;

  typedef struct packed {
    logic [REC_POS_W-1:0] start;
    logic [REC_LEN_W-1:0] len;
  } tok_rec_t;

  function automatic logic is_delim(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_NEWLINE) || (c == CH_COMMA) || (c == CH_SEMI);
  endfunction

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; reports writes it had to drop.
// The head reads as zero while empty so consumers never see stale data.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             wr_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_rd;
  logic             do_wr;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
    do_rd    = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    do_wr    = wr_en && (!full || do_rd);
    wr_drop  = wr_en && !do_wr;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/id_token_collector.sv
// Splits the character stream into tokens at delimiters and queues a
// {start, length} record for every token the recognizer accepted.
module id_token_collector
  import tok_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POS_W      = 16,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_start,
  output logic [LEN_W-1:0] out_len,
  output logic [15:0]      id_count,
  output logic             overflow
);

  localparam int unsigned REC_W = POS_W + LEN_W;

  tok_state_e       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] tok_start_q, tok_start_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             first_alpha_q, first_alpha_d;
  logic [15:0]      id_count_q, id_count_d;
  logic             overflow_q, overflow_d;

  logic             emit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             pop;
  logic [REC_W-1:0] head;

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    tok_start_d   = tok_start_q;
    tok_len_d     = tok_len_q;
    first_alpha_d = first_alpha_q;
    id_count_d    = id_count_q;
    overflow_d    = overflow_q;
    emit          = 1'b0;

    if (in_valid) begin
      pos_d = pos_q + 1'b1;
      unique case (state_q)
        GAP: begin
          if (!is_delim(in_char)) begin
            tok_start_d   = pos_q;
            tok_len_d     = LEN_W'(1);
            first_alpha_d = is_alpha(in_char);
            state_d       = TOKEN;
          end
        end
        TOKEN: begin
          if (!is_delim(in_char)) begin
            if (tok_len_q != {LEN_W{1'b1}}) tok_len_d = tok_len_q + 1'b1;
          end else begin
            // A leading digit means the recognizer restarted inside the token.
            emit    = in_match && first_alpha_q;
            state_d = GAP;
          end
        end
        default: state_d = GAP;
      endcase
    end

    if (emit) begin
      if (id_count_q != 16'hFFFF) id_count_d = id_count_q + 1'b1;
      if (fifo_drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= GAP;
      pos_q         <= '0;
      tok_start_q   <= '0;
      tok_len_q     <= '0;
      first_alpha_q <= 1'b0;
      id_count_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      tok_start_q   <= tok_start_d;
      tok_len_q     <= tok_len_d;
      first_alpha_q <= first_alpha_d;
      id_count_q    <= id_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pop = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (emit),
    .wr_data ({tok_start_q, tok_len_q}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .wr_drop (fifo_drop)
  );

  assign out_valid = !fifo_empty;
  assign out_start = head[REC_W-1:LEN_W];
  assign out_len   = head[LEN_W-1:0];
  assign id_count  = id_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_id_token_collector.sv
// Scoreboard bench for id_token_collector: a recognizer model drives in_match,
// a token model queues expected records, and a monitor checks every pop.
module tb_id_token_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_match = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_start;
  logic [7:0]  out_len;
  logic [15:0] id_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct { int s; int l; } rec_t;
  rec_t exp_q[$];

  // Recognizer model: 0 idle, 1 in letters, 2 in digits after letters.
  int rec_st = 0;
  // Token model.
  bit m_tok = 0;
  int m_pos = 0, m_start = 0, m_len = 0;
  bit m_fa = 0;
  int exp_ids = 0;
  bit exp_ovf = 0;

  always #5 clk = ~clk;

  id_token_collector #(.FIFO_DEPTH(DEPTH), .POS_W(16), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_match  (in_match),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_start (out_start),
    .out_len   (out_len),
    .id_count  (id_count),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_delim(input logic [7:0] c);
    return c == 8'h20 || c == 8'h0A || c == 8'h2C || c == 8'h3B;
  endfunction

  function automatic bit m_alpha(input logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
  endfunction

  function automatic bit m_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", {out_start, out_len}, 32'h0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("out_start", 32'(out_start), r.s);
        chk("out_len", 32'(out_len), r.l);
        pops++;
      end
    end
  end

  task automatic reset_dut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rec_st  = 0;
    m_tok   = 0;
    m_pos   = 0;
    exp_ids = 0;
    exp_ovf = 0;
    pops    = 0;
    exp_q.delete();
  endtask

  task automatic send_char(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    in_match = (rec_st == 2);
    @(posedge clk);
    if (!m_tok) begin
      if (!m_delim(c)) begin
        m_start = m_pos & 16'hFFFF;
        m_len   = 1;
        m_fa    = m_alpha(c);
        m_tok   = 1;
      end
    end else if (!m_delim(c)) begin
      if (m_len < 255) m_len++;
    end else begin
      if (in_match && m_fa) begin
        if (exp_ids < 16'hFFFF) exp_ids++;
        if (exp_q.size() < DEPTH) exp_q.push_back('{m_start, m_len});
        else exp_ovf = 1;
      end
      m_tok = 0;
    end
    m_pos++;
    if (m_delim(c))               rec_st = 0;
    else if (m_alpha(c))          rec_st = 1;
    else if (m_digit(c) && rec_st != 0) rec_st = 2;
    else                          rec_st = 0;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_id_count"}, 32'(id_count), exp_ids);
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_idle"}, 32'(out_valid), 0);
  endtask

  initial begin
    string s300;

    reset_dut();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_start", 32'(out_start), 0);
    chk("rst_out_len", 32'(out_len), 0);
    chk("rst_id_count", 32'(id_count), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // "ab12," : one record, visible one cycle after the delimiter edge.
    out_ready = 1'b1;
    send_str("ab12,");
    chk("t1_queued", exp_q.size(), 1);
    @(negedge clk);
    chk("t1_latency", 32'(out_valid), 1);
    @(negedge clk);
    chk("t1_single_pulse", 32'(out_valid), 0);
    chk("t1_pops", pops, 1);
    drain("t1");
    chk("t1_ids_const", 32'(id_count), 1);

    // "abc;x9 " : only x9 is an identifier, start 4 length 2.
    reset_dut();
    send_str("abc;");
    send_char(8'h00); // non-delimiter control char is treated as a token char below
    reset_dut();
    send_str("abc;x9 ");
    drain("t2");
    chk("t2_ids_const", 32'(id_count), 1);
    chk("t2_pops", pops, 1);

    // "1ab2," : recognizer matches at ',' but the token began with a digit.
    reset_dut();
    send_str("1ab2");
    chk("t3_match_high", 32'(rec_st == 2), 1);
    send_char(",");
    drain("t3");
    chk("t3_ids_zero", 32'(id_count), 0);

    // Six "a1," with the consumer stalled: four kept, two dropped.
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_str("a1,");
    @(negedge clk);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_id_count", 32'(id_count), 6);
    chk("t4_held_valid", 32'(out_valid), 1);
    chk("t4_held_start", 32'(out_start), 0);
    out_ready = 1'b1;
    drain("t4");
    chk("t4_pops", pops, 4);

    // 300-character identifier: length saturates at 255.
    reset_dut();
    s300 = "a";
    for (int i = 0; i < 299; i++) s300 = {s300, "1"};
    send_str(s300);
    send_char(" ");
    drain("t5");
    chk("t5_pops", pops, 1);

    // Reset mid-token discards it; the next token restarts from position 1.
    reset_dut();
    send_str("ab1");
    reset_dut();
    send_char(",");
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_start", 32'(out_start), 0);
    chk("t6_len", 32'(out_len), 0);
    chk("t6_ids", 32'(id_count), 0);
    chk("t6_ovf", 32'(overflow), 0);
    send_str("z7;");
    drain("t6");
    chk("t6_pops", pops, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
